gshare_pc_ctrl: RTL

- Next-PC controller for the fetch stage. It generates the 2-bit select for the 4-input next-PC mux and the predicted target it needs.
- Prediction uses a gshare scheme: a global history register (GHR), a table of 2-bit counters (PHT) and a direct-mapped BTB.
- EX-stage resolution is fed back to train the tables, detect mispredictions, redirect fetch and raise a flush.

---
 rtl/gshare_pc_ctrl_pkg.sv | 28 ++
 rtl/gshare_pc_ctrl_pht.sv | 32 +++
 rtl/gshare_pc_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/gshare_pc_ctrl_pkg.sv
// Shared constants, BTB entry layout and counter helper for the gshare next-PC controller.
package gshare_pc_ctrl_pkg;

  localparam int XLEN_DEF         = 32;
  localparam int GHR_BITS_DEF     = 5;
  localparam int BTB_IDX_BITS_DEF = 5;
  localparam int BTB_TAG_W        = XLEN_DEF - BTB_IDX_BITS_DEF - 2;

  localparam logic [1:0] PC_SEL_SEQ    = 2'b00;
  localparam logic [1:0] PC_SEL_PRED   = 2'b01;
  localparam logic [1:0] PC_SEL_EX_TGT = 2'b10;
  localparam logic [1:0] PC_SEL_EX_SEQ = 2'b11;

  localparam logic [1:0] CTR_RESET = 2'b01;

  typedef struct packed {
    logic                  valid;
    logic                  is_jump;
    logic [BTB_TAG_W-1:0]  tag;
    logic [XLEN_DEF-1:0]   target;
  } btb_entry_t;

  function automatic logic [1:0] sat_step(input logic [1:0] ctr, input logic inc);
    if (inc) return (ctr == 2'b11) ? ctr : ctr + 2'd1;
    else     return (ctr == 2'b00) ? ctr : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/gshare_pc_ctrl_pht.sv
// Pattern history table: 2-bit saturating counters, async read, sync inc/dec write.
module pht_2bit
  import gshare_pc_ctrl_pkg::*;
#(
  parameter int IDX_BITS = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IDX_BITS-1:0] i_rd_idx,
  output logic [1:0]          o_rd_ctr,
  input  logic                i_wr_en,
  input  logic [IDX_BITS-1:0] i_wr_idx,
  input  logic                i_wr_inc
);

  localparam int ENTRIES = 1 << IDX_BITS;

  logic [1:0] r_ctr [ENTRIES];

  // NOTE: this table is built from flops, not RAM, because every counter must
  // come out of reset weakly not-taken; a RAM macro could not be cleared in one cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) r_ctr[i] <= CTR_RESET;
    end else if (i_wr_en) begin
      r_ctr[i_wr_idx] <= sat_step(r_ctr[i_wr_idx], i_wr_inc);
    end
  end

  assign o_rd_ctr = r_ctr[i_rd_idx];

endmodule

// File: rtl/gshare_pc_ctrl.sv
// Fetch next-PC controller: gshare direction predictor + BTB, trained and corrected from EX.
module gshare_pc_ctrl
  import gshare_pc_ctrl_pkg::*;
#(
  parameter int XLEN         = XLEN_DEF,
  parameter int GHR_BITS     = GHR_BITS_DEF,
  parameter int BTB_IDX_BITS = BTB_IDX_BITS_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_stall,
  input  logic [XLEN-1:0]     if_pc,
  output logic [1:0]          pc_sel,
  output logic [XLEN-1:0]     pred_target,
  output logic                if_pred_taken,
  output logic [GHR_BITS-1:0] if_ghr,
  input  logic                ex_valid,
  input  logic                ex_is_branch,
  input  logic                ex_is_jump,
  input  logic [XLEN-1:0]     ex_pc,
  input  logic                ex_taken,
  input  logic [XLEN-1:0]     ex_target,
  input  logic                ex_pred_taken,
  input  logic [XLEN-1:0]     ex_pred_target,
  input  logic [GHR_BITS-1:0] ex_ghr,
  output logic                flush
);

  localparam int BTB_ENTRIES = 1 << BTB_IDX_BITS;
  localparam int TAG_W       = XLEN - BTB_IDX_BITS - 2;

  btb_entry_t          r_btb [BTB_ENTRIES];
  logic [GHR_BITS-1:0] r_ghr;

  logic [BTB_IDX_BITS-1:0] w_if_idx, w_ex_idx;
  logic [TAG_W-1:0]        w_if_tag, w_ex_tag;
  btb_entry_t              w_if_entry;
  logic                    w_hit, w_pred_taken, w_is_ctrl, w_mispred;
  logic                    w_btb_alloc, w_btb_kill, w_pht_wr_en;
  logic [GHR_BITS-1:0]     w_pht_rd_idx, w_pht_wr_idx, w_ghr_next;
  logic [1:0]              w_pht_rd_ctr;
  logic                    w_unused_bits;

  // Fetch-side lookup
  assign w_if_idx     = if_pc[BTB_IDX_BITS+1:2];
  assign w_if_tag     = if_pc[XLEN-1:BTB_IDX_BITS+2];
  assign w_if_entry   = r_btb[w_if_idx];
  assign w_hit        = w_if_entry.valid && (w_if_entry.tag == w_if_tag);
  assign w_pht_rd_idx = r_ghr ^ if_pc[GHR_BITS+1:2];
  assign w_pred_taken = w_hit && (w_if_entry.is_jump || w_pht_rd_ctr[1]);

  pht_2bit #(.IDX_BITS(GHR_BITS)) u_pht (
    .clk      (clk),
    .reset    (reset),
    .i_rd_idx (w_pht_rd_idx),
    .o_rd_ctr (w_pht_rd_ctr),
    .i_wr_en  (w_pht_wr_en),
    .i_wr_idx (w_pht_wr_idx),
    .i_wr_inc (ex_taken)
  );

  // EX-side resolution; a non-control instruction predicted taken is a BTB alias
  assign w_ex_idx    = ex_pc[BTB_IDX_BITS+1:2];
  assign w_ex_tag    = ex_pc[XLEN-1:BTB_IDX_BITS+2];
  assign w_is_ctrl   = ex_is_branch || ex_is_jump;
  assign w_mispred   = ex_valid && (w_is_ctrl
                         ? ((ex_taken != ex_pred_taken) ||
                            (ex_taken && ex_pred_taken && (ex_target != ex_pred_target)))
                         : ex_pred_taken);
  assign w_btb_alloc = ex_valid && w_is_ctrl && ex_taken;
  assign w_btb_kill  = ex_valid && !w_is_ctrl && ex_pred_taken;
  assign w_pht_wr_en = ex_valid && ex_is_branch;
  assign w_pht_wr_idx = ex_ghr ^ ex_pc[GHR_BITS+1:2];

  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned and infers a latch.
  always_comb begin
    pc_sel = PC_SEL_SEQ;
    if (reset) begin
      if (w_mispred)         pc_sel = ex_taken ? PC_SEL_EX_TGT : PC_SEL_EX_SEQ;
      else if (w_pred_taken) pc_sel = PC_SEL_PRED;
    end
  end

  assign flush         = reset && w_mispred;
  assign if_pred_taken = reset && w_pred_taken;
  assign pred_target   = w_if_entry.target;
  assign if_ghr        = r_ghr;

  // Repair from EX wins over speculative fetch shift; jumps never shift history
  always_comb begin
    w_ghr_next = r_ghr;
    if (w_mispred && ex_is_branch)                    w_ghr_next = {ex_ghr[GHR_BITS-2:0], ex_taken};
    else if (w_mispred)                               w_ghr_next = ex_ghr;
    else if (!if_stall && w_hit && !w_if_entry.is_jump) w_ghr_next = {r_ghr[GHR_BITS-2:0], w_pred_taken};
  end

  // NOTE: state registers use non-blocking assignment so all flops see
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (!reset) r_ghr <= '0;
    else        r_ghr <= w_ghr_next;
  end

  // Only valid bits are cleared; tag/target/is_jump are meaningless until valid is set.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < BTB_ENTRIES; i++) r_btb[i].valid <= 1'b0;
    end else if (w_btb_alloc) begin
      r_btb[w_ex_idx] <= '{valid: 1'b1, is_jump: ex_is_jump, tag: w_ex_tag, target: ex_target};
    end else if (w_btb_kill) begin
      r_btb[w_ex_idx].valid <= 1'b0;
    end
  end

  assign w_unused_bits = &{1'b0, if_pc[1:0], ex_pc[1:0]};

endmodule
